// File: rtl/id_pkg.sv
// id_pkg: shared decode definitions for the instruction-decode stage.
//   - opcode values for the op[4]=1 group (LD, ST, ADI, SHF, BRZ, BRNZ, JMP, OUT)
//   - MD (datapath result select) and BS (branch select) encodings
//   - ctrl_flags_t: the width-independent part of the datapath control word.
// A package cannot take parameters, so the RA_W/SH_W dependent control word
// (ctrl_word_t) is assembled from ctrl_flags_t inside id_pipe_stage.
package id_pkg;

  localparam logic [4:0] OP_LD   = 5'b10000;
  localparam logic [4:0] OP_ST   = 5'b10001;
  localparam logic [4:0] OP_ADI  = 5'b10010;
  localparam logic [4:0] OP_SHF  = 5'b10011;
  localparam logic [4:0] OP_BRZ  = 5'b10100;
  localparam logic [4:0] OP_BRNZ = 5'b10101;
  localparam logic [4:0] OP_JMP  = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;

  // MD: which source writes the register file
  localparam logic [1:0] MD_FU  = 2'b00;  // function unit
  localparam logic [1:0] MD_MEM = 2'b01;  // data memory
  localparam logic [1:0] MD_SHF = 2'b10;  // shifter

  // BS: program-counter update
  localparam logic [1:0] BS_NONE = 2'b00;  // increment
  localparam logic [1:0] BS_COND = 2'b01;  // conditional branch (PS picks polarity)
  localparam logic [1:0] BS_JUMP = 2'b10;  // unconditional jump

  typedef struct packed {
    logic       rw;
    logic [1:0] md;
    logic [1:0] bs;
    logic       ps;
    logic       mw;
    logic [3:0] fs;
    logic       ma;
    logic       mb;
    logic       cs;
    logic       owe;
  } ctrl_flags_t;

endpackage

// File: rtl/id_decode_comb.sv
// id_decode_comb: purely combinational opcode -> control flags decoder.
// Ports:
//   opcode  in   5-bit opcode field of the instruction
//   flags   out  decoded control flags (RW, MD, BS, PS, MW, FS, MA, MB, CS, OUT enable)
//   illegal out  opcode is in the undefined 11xxx group
// Register-address and shift fields are passed through by the caller.
module id_decode_comb
  import id_pkg::*;
(
  input  logic [4:0]  opcode,
  output ctrl_flags_t flags,
  output logic        illegal
);

  always_comb begin
    flags    = '0;
    flags.md = MD_FU;
    flags.bs = BS_NONE;
    illegal  = 1'b0;
    if (!opcode[4]) begin
      // register-register ALU op: low opcode bits select the function directly
      flags.fs = opcode[3:0];
      flags.rw = 1'b1;
    end else begin
      case (opcode)
        OP_LD: begin
          flags.rw = 1'b1;
          flags.md = MD_MEM;
        end
        OP_ST: flags.mw = 1'b1;
        OP_ADI: begin
          flags.rw = 1'b1;
          flags.mb = 1'b1;
          flags.fs = 4'b0010;
        end
        OP_SHF: begin
          flags.rw = 1'b1;
          flags.md = MD_SHF;
        end
        OP_BRZ: begin
          flags.bs = BS_COND;
          flags.mb = 1'b1;
          flags.cs = 1'b1;
        end
        OP_BRNZ: begin
          flags.bs = BS_COND;
          flags.ps = 1'b1;
          flags.mb = 1'b1;
          flags.cs = 1'b1;
        end
        OP_JMP:  flags.bs  = BS_JUMP;
        OP_OUT:  flags.owe = 1'b1;
        default: illegal   = 1'b1;  // 11xxx: behaves as a NOP
      endcase
    end
  end

endmodule

// File: rtl/id_pipe_stage.sv
// id_pipe_stage: registered instruction-decode pipeline stage.
// Decodes an instruction word (opcode, DR, SA, SB, SHF from MSB to LSB) into
// the datapath control word, registers it, and inserts one bubble when an
// instruction reads the destination of the immediately preceding LD.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready instruction handshake from fetch
//   instruction         INSTR_W-bit instruction word
//   out_valid/out_ready control-word handshake to the datapath
//   RW DA MD BS PS MW FS MA MB AA BA CS SH output_write_enable
//                       registered control word
//   illegal             registered; word came from an undefined opcode
// Optional build macro: ID_ILLEGAL_TRAP_EN -- the first accepted illegal word
// sets a sticky trap that holds in_ready low until rst.
//
// Handshake: a word moves only on a rising edge where valid && ready are both
// high; valid never depends on ready, and the output register holds its
// contents unchanged while out_valid && !out_ready.
module id_pipe_stage
  import id_pkg::*;
#(
  parameter int RA_W    = 3,
  parameter int SH_W    = 3,
  parameter int OPC_W   = 5,
  parameter int INSTR_W = OPC_W + 3 * RA_W + SH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               RW,
  output logic [RA_W-1:0]    DA,
  output logic [1:0]         MD,
  output logic [1:0]         BS,
  output logic               PS,
  output logic               MW,
  output logic [3:0]         FS,
  output logic               MA,
  output logic               MB,
  output logic [RA_W-1:0]    AA,
  output logic [RA_W-1:0]    BA,
  output logic               CS,
  output logic [SH_W-1:0]    SH,
  output logic               output_write_enable,
  output logic               illegal
);

  if (OPC_W != 5) begin : g_bad_opc_w
    $error("id_pipe_stage: OPC_W must be 5");
  end

  typedef struct packed {
    ctrl_flags_t     flags;
    logic [RA_W-1:0] da;
    logic [RA_W-1:0] aa;
    logic [RA_W-1:0] ba;
    logic [SH_W-1:0] sh;
    logic            illegal;
  } ctrl_word_t;

  logic [4:0]      opcode;
  logic [RA_W-1:0] dr, sa, sb;
  logic [SH_W-1:0] shf;

  assign opcode = instruction[INSTR_W-1 -: 5];
  assign dr     = instruction[SH_W + 3*RA_W - 1 -: RA_W];
  assign sa     = instruction[SH_W + 2*RA_W - 1 -: RA_W];
  assign sb     = instruction[SH_W + RA_W - 1 -: RA_W];
  assign shf    = instruction[SH_W-1:0];

  ctrl_flags_t dec_flags;
  logic        dec_illegal;
  ctrl_word_t  dec_word;

  id_decode_comb u_decode (
    .opcode  (opcode),
    .flags   (dec_flags),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec_word         = '0;
    dec_word.flags   = dec_flags;
    dec_word.da      = dr;
    dec_word.aa      = sa;
    dec_word.ba      = sb;
    dec_word.sh      = shf;
    dec_word.illegal = dec_illegal;
  end

  ctrl_word_t      out_q;
  logic            out_valid_q;
  logic            ready_en_q;  // keeps in_ready low for the first cycle out of reset
  logic            ld_pend_q;   // last issued word was an LD
  logic [RA_W-1:0] ld_da_q;     // destination of that LD
  logic            trap_q;
  logic            slot_free, hazard, accept;

  assign slot_free = !out_valid_q || out_ready;
  // JMP is the only opcode that reads no register operand.
  assign hazard    = in_valid && ld_pend_q && (opcode != OP_JMP) &&
                     ((ld_da_q == sa) || (ld_da_q == sb));
  assign in_ready  = ready_en_q && slot_free && !hazard && !trap_q;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ready_en_q  <= 1'b0;
      ld_pend_q   <= 1'b0;
      ld_da_q     <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        out_q       <= dec_word;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        ld_pend_q <= (opcode == OP_LD);
        ld_da_q   <= dr;
      end else if (hazard && slot_free) begin
        // The stall edge also drains the LD, so the bubble is complete;
        // if the LD is still held, keep stalling until it is consumed.
        ld_pend_q <= 1'b0;
      end
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else if (accept && dec_illegal) begin
      trap_q <= 1'b1;
    end
  end
`else
  assign trap_q = 1'b0;
`endif

  assign out_valid           = out_valid_q;
  assign RW                  = out_q.flags.rw;
  assign DA                  = out_q.da;
  assign MD                  = out_q.flags.md;
  assign BS                  = out_q.flags.bs;
  assign PS                  = out_q.flags.ps;
  assign MW                  = out_q.flags.mw;
  assign FS                  = out_q.flags.fs;
  assign MA                  = out_q.flags.ma;
  assign MB                  = out_q.flags.mb;
  assign AA                  = out_q.aa;
  assign BA                  = out_q.ba;
  assign CS                  = out_q.flags.cs;
  assign SH                  = out_q.sh;
  assign output_write_enable = out_q.flags.owe;
  assign illegal             = out_q.illegal;

endmodule

// File: tb/tb_id_pipe_stage.sv
// tb_id_pipe_stage: directed + randomized bench for id_pipe_stage (default
// parameters, 17-bit instruction). Expected control words come from a
// decode-table model; a queue scoreboard checks every transferred word.
module tb_id_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic        RW, PS, MW, MA, MB, CS, output_write_enable, illegal;
  logic [2:0]  DA, AA, BA, SH;
  logic [1:0]  MD, BS;
  logic [3:0]  FS;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic rand_mode = 1'b0;

  logic [27:0] exp_q[$];
  logic [27:0] obs_vec;

  id_pipe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .RW(RW), .DA(DA), .MD(MD), .BS(BS), .PS(PS), .MW(MW), .FS(FS), .MA(MA),
    .MB(MB), .AA(AA), .BA(BA), .CS(CS), .SH(SH),
    .output_write_enable(output_write_enable), .illegal(illegal)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #200000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign obs_vec = {RW, DA, MD, BS, PS, MW, FS, MA, MB, AA, BA, CS, SH,
                    output_write_enable, illegal};

  // Decode-table model: value of the opcode selects the control settings.
  function automatic logic [27:0] model(input logic [16:0] ins);
    logic [4:0] op;
    logic rw, ps, mw, ma, mb, cs, owe, ill;
    logic [1:0] md, bs;
    logic [3:0] fs;
    op = ins[16:12];
    rw = 0; ps = 0; mw = 0; ma = 0; mb = 0; cs = 0; owe = 0; ill = 0;
    md = 0; bs = 0; fs = 0;
    if (op < 16) begin
      fs = op[3:0]; rw = 1;
    end else if (op >= 24) begin
      ill = 1;
    end else begin
      case (op - 5'd16)
        5'd0: begin rw = 1; md = 2'd1; end
        5'd1: mw = 1;
        5'd2: begin rw = 1; mb = 1; fs = 4'd2; end
        5'd3: begin rw = 1; md = 2'd2; end
        5'd4: begin bs = 2'd1; mb = 1; cs = 1; end
        5'd5: begin bs = 2'd1; ps = 1; mb = 1; cs = 1; end
        5'd6: bs = 2'd2;
        default: owe = 1;
      endcase
    end
    return {rw, ins[11:9], md, bs, ps, mw, fs, ma, mb, ins[8:6], ins[5:3], cs,
            ins[2:0], owe, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: push on accept, pop on transfer; also checks load-use spacing
  logic       last_ld;
  logic [2:0] last_ld_da;
  int         last_ld_cyc;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_ld = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $error("FAIL sb_underflow observed=%0h expected=none", obs_vec);
        end else begin
          check("sb_word", 32'(obs_vec), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(instruction));
        if (last_ld && instruction[16:12] != 5'b10110 &&
            (instruction[8:6] == last_ld_da || instruction[5:3] == last_ld_da))
          check("load_use_gap", 32'(cyc - last_ld_cyc >= 2), 32'd1);
        last_ld     = (instruction[16:12] == 5'b10000);
        last_ld_da  = instruction[11:9];
        last_ld_cyc = cyc;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // driver: present a word and hold it until it is accepted
  task automatic send(input logic [16:0] ins);
    int n;
    n = 0;
    in_valid = 1'b1;
    instruction = ins;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 40) begin
        checks++; failures++;
        $error("FAIL send_timeout observed=in_ready_low expected=accept ins=%0h", ins);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    logic [16:0] ins;
    logic [4:0]  op;
    int          t0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instruction = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_ctrl_word", 32'(obs_vec), 0);
    rst = 1'b0;
    check("rst_in_ready_low", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(in_ready), 1);

    // 1: ALU register op
    send(17'b01111_010_110_001_000);
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_fs", 32'(FS), 32'hf);
    check("t1_rw", 32'(RW), 1);
    check("t1_da_aa_ba", 32'({DA, AA, BA}), 32'({3'd2, 3'd6, 3'd1}));
    check("t1_mb", 32'(MB), 0);

    // 2: LD then dependent ALU -> one bubble
    send(17'b10000_011_000_000_000);
    in_valid = 1'b1; instruction = 17'b00010_001_011_000_000;
    @(negedge clk);
    check("t2_stall_in_ready", 32'(in_ready), 0);
    check("t2_ld_out_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    check("t2_bubble_out_valid", 32'(out_valid), 0);
    check("t2_after_bubble_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t2_alu_out_valid", 32'(out_valid), 1);
    check("t2_alu_word", 32'(obs_vec), 32'(model(17'b00010_001_011_000_000)));

    // 3: ADI held under back-pressure
    send(17'b10010_100_010_010_000);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t3_hold_valid", 32'(out_valid), 1);
      check("t3_hold_word", 32'(obs_vec), 32'(model(17'b10010_100_010_010_000)));
      check("t3_mb_cs", 32'({MB, CS}), 32'b10);
      check("t3_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_released", 32'(out_valid), 0);

    // 4: back-to-back branch/jump/out at full throughput
    t0 = cyc;
    send(17'b10100_000_001_010_011);
    check("t4_brz_bs_ps", 32'({BS, PS}), 32'b010);
    send(17'b10101_000_001_010_011);
    check("t4_brnz_bs_ps", 32'({BS, PS}), 32'b011);
    send(17'b10110_000_001_010_011);
    check("t4_jmp_bs", 32'(BS), 32'b10);
    send(17'b10111_101_001_010_011);
    check("t4_out_owe", 32'(output_write_enable), 1);
    check("t4_cycles", 32'(cyc - t0), 4);

    // 5: illegal opcode
    send(17'b11010_001_010_011_101);
    check("t5_illegal", 32'(illegal), 1);
    check("t5_rw_mw_owe", 32'({RW, MW, output_write_enable}), 0);
`ifdef ID_ILLEGAL_TRAP_EN
    in_valid = 1'b1; instruction = 17'b00001_001_010_011_000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_trap_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("t5_trap_cleared", 32'(in_ready), 1);
`else
    send(17'b00001_001_010_011_000);
    check("t5_next_accepted", 32'(obs_vec), 32'(model(17'b00001_001_010_011_000)));
    @(posedge clk); #1;
`endif

    // 6: reset with a held word
    out_ready = 1'b0;
    send(17'b00011_110_101_100_111);
    check("t6_held_valid", 32'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_word", 32'(obs_vec), 0);
    rst = 1'b0; out_ready = 1'b1;

    // randomized traffic: LD-heavy, small register range to provoke hazards
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) op = 5'b10000;
`ifdef ID_ILLEGAL_TRAP_EN
      else op = 5'($urandom_range(0, 23));
`else
      else op = 5'($urandom_range(0, 31));
`endif
      ins = {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
             3'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(ins);
    end
    rand_mode = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
